// File: rtl/ofdm_cp_remover.sv
// OFDM cyclic-prefix remover: drops cp_len samples, then forwards 2^fft_len_log2 samples per symbol.
// Sizes are shadowed at symbol start so a settings write never disturbs the symbol in flight.
module ofdm_cp_remover #(
  parameter int unsigned BASE  = 0,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             clear,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             trunc
);

  localparam int unsigned AddrCpInt = BASE + 1;
  localparam logic [7:0]  AddrFft   = BASE[7:0];
  localparam logic [7:0]  AddrCp    = AddrCpInt[7:0];

  typedef enum logic {StDrop, StPass} state_e;

  state_e           state_q, state_d, st_cur;
  logic [9:0]       cnt_q, cnt_d;
  logic             sym_start_q, sym_start_d;
  logic [3:0]       fft_q, fft_d, fft_sh_q, fft_sh_d, fft_cur;
  logic [9:0]       cp_q, cp_d, cp_sh_q, cp_sh_d, cp_cur, cp_last;
  logic [10:0]      pass_last;
  logic [WIDTH-1:0] odata_q, odata_d;
  logic             olast_q, olast_d;
  logic             ovalid_q, ovalid_d;
  logic             trunc_q, trunc_d;
  logic             accept, sym_end;
  logic             unused_set;

  assign unused_set = ^set_data[31:10];

  function automatic logic [3:0] clamp_fft(input logic [3:0] v);
    if (v < 4'd3) begin
      return 4'd3;
    end else if (v > 4'd10) begin
      return 4'd10;
    end
    return v;
  endfunction

  assign i_tready = ~ovalid_q | o_tready;
  assign accept   = i_tvalid & i_tready;
  assign o_tdata  = odata_q;
  assign o_tlast  = olast_q;
  assign o_tvalid = ovalid_q;
  assign trunc    = trunc_q;

  always_comb begin
    fft_d = fft_q;
    cp_d  = cp_q;
    if (set_stb && (set_addr == AddrFft)) begin
      fft_d = clamp_fft(set_data[3:0]);
    end
    if (set_stb && (set_addr == AddrCp)) begin
      cp_d = set_data[9:0];
    end
  end

  // At symbol start the live registers (including a same-cycle write) define the symbol.
  always_comb begin
    fft_cur   = sym_start_q ? fft_d : fft_sh_q;
    cp_cur    = sym_start_q ? cp_d : cp_sh_q;
    st_cur    = sym_start_q ? ((cp_cur == 10'd0) ? StPass : StDrop) : state_q;
    pass_last = (11'd1 << fft_cur) - 11'd1;
    cp_last   = cp_cur - 10'd1;
    sym_end   = ({1'b0, cnt_q} == pass_last);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sym_start_d = sym_start_q;
    fft_sh_d    = fft_sh_q;
    cp_sh_d     = cp_sh_q;
    odata_d     = odata_q;
    olast_d     = olast_q;
    ovalid_d    = ovalid_q;
    trunc_d     = 1'b0;

    if (sym_start_q) begin
      fft_sh_d = fft_d;
      cp_sh_d  = cp_d;
    end
    if (i_tready) begin
      ovalid_d = 1'b0;
    end

    if (accept) begin
      sym_start_d = 1'b0;
      state_d     = st_cur;
      unique case (st_cur)
        StDrop: begin
          if (i_tlast) begin
            trunc_d     = 1'b1;
            cnt_d       = 10'd0;
            sym_start_d = 1'b1;
            state_d     = StDrop;
          end else if (cnt_q == cp_last) begin
            cnt_d   = 10'd0;
            state_d = StPass;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
        StPass: begin
          ovalid_d = 1'b1;
          odata_d  = i_tdata;
          olast_d  = sym_end | i_tlast;
          if (sym_end || i_tlast) begin
            trunc_d     = ~sym_end;
            cnt_d       = 10'd0;
            // A zero-length CP resolves to PASS at the next symbol start.
            sym_start_d = 1'b1;
            state_d     = StDrop;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
        default: state_d = StDrop;
      endcase
    end

    if (clear) begin
      ovalid_d    = 1'b0;
      trunc_d     = 1'b0;
      state_d     = StDrop;
      cnt_d       = 10'd0;
      sym_start_d = 1'b1;
      fft_sh_d    = fft_d;
      cp_sh_d     = cp_d;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= StDrop;
      cnt_q       <= 10'd0;
      sym_start_q <= 1'b1;
      fft_q       <= 4'd6;
      cp_q        <= 10'd16;
      fft_sh_q    <= 4'd6;
      cp_sh_q     <= 10'd16;
      odata_q     <= '0;
      olast_q     <= 1'b0;
      ovalid_q    <= 1'b0;
      trunc_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sym_start_q <= sym_start_d;
      fft_q       <= fft_d;
      cp_q        <= cp_d;
      fft_sh_q    <= fft_sh_d;
      cp_sh_q     <= cp_sh_d;
      odata_q     <= odata_d;
      olast_q     <= olast_d;
      ovalid_q    <= ovalid_d;
      trunc_q     <= trunc_d;
    end
  end

endmodule

// File: doc/ofdm_cp_remover.md
OFDM_CP_REMOVER -- requirements
Module: ofdm_cp_remover

Interface
REQ-001 Parameter BASE, default 0: settings-bus base address of this block.
REQ-002 Parameter WIDTH, default 32: sample width as {I[WIDTH-1:WIDTH/2], Q[WIDTH/2-1:0]}.
REQ-003 Port clk, input, 1: single clock; all logic SHALL be on its rising edge.
REQ-004 Port aresetn, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port clear, input, 1: synchronous soft clear.
REQ-006 Port set_stb, input, 1: settings write strobe.
REQ-007 Port set_addr, input, 8: settings address.
REQ-008 Port set_data, input, 32: settings data.
REQ-009 Port i_tdata / i_tlast / i_tvalid, input, WIDTH/1/1: framed CP+symbol samples from the periodic framer; tlast marks end of burst.
REQ-010 Port i_tready, output, 1: input accept.
REQ-011 Port o_tdata / o_tlast / o_tvalid, output, WIDTH/1/1: CP-stripped samples; tlast marks last sample of each symbol (FFT frame).
REQ-012 Port o_tready, input, 1: output accept.
REQ-013 Port trunc, output, 1: one-cycle pulse when a burst ends inside a symbol.

Function
REQ-014 The block SHALL implement register BASE+0 bits[3:0] fft_len_log2 (legal 3..10; writes outside that range SHALL be clamped to 3 or 10).
REQ-015 The block SHALL implement register BASE+1 bits[9:0] cp_len (0..1023).
REQ-016 The block SHALL latch both registers into shadow copies only at the start of a symbol, i.e. when the input sample counter is 0, so a write never changes the current symbol.
REQ-017 The block SHALL run a two-state FSM: DROP, which discards the first cp_len samples, and PASS, which forwards the next 2^fft_len_log2 samples.
REQ-018 The FSM SHALL enter PASS directly from symbol start when cp_len=0.
REQ-019 In DROP, each accepted input beat SHALL increment the counter; at count cp_len-1 the FSM SHALL go to PASS and clear the counter.
REQ-020 In PASS, each accepted beat SHALL be forwarded; the beat at count 2^N-1 SHALL carry o_tlast=1, after which the FSM SHALL go to DROP (or stay in PASS if cp_len=0) with the counter cleared.
REQ-021 The output SHALL be a single registered stage: o_tdata/o_tlast/o_tvalid registered, latency exactly 1 cycle from input accept.
REQ-022 i_tready SHALL equal (~o_tvalid | o_tready) in both states, so dropped beats also obey backpressure.
REQ-023 Full throughput SHALL be sustained: one beat per cycle with o_tready held high.
REQ-024 When an input beat with i_tlast=1 arrives in PASS before the symbol end, it SHALL be forwarded with o_tlast=1, trunc SHALL pulse on the same cycle o_tvalid rises for it, and the FSM SHALL return to DROP with counter 0.
REQ-025 When i_tlast=1 arrives in DROP, the beat SHALL be discarded, trunc SHALL pulse, and the FSM SHALL return to DROP with counter 0.
REQ-026 An i_tlast=1 coinciding with the natural symbol end SHALL NOT pulse trunc.
REQ-027 A settings write in the same cycle as symbol start SHALL take effect for that symbol.
REQ-028 clear SHALL set o_tvalid=0, discard any held beat, force DROP with counter 0, and reload shadows from the registers; settings register values SHALL be preserved.
REQ-029 clear SHALL take priority over a simultaneous input handshake.

Reset
REQ-030 On aresetn low, asynchronously: o_tvalid=0, o_tlast=0, o_tdata=0, trunc=0, FSM=DROP, counter=0, fft_len_log2=6, cp_len=16 (802.11a defaults).
REQ-031 After aresetn deasserts, i_tready SHALL be 1 on the first clock edge.
REQ-032 Reset asserted mid-symbol SHALL discard all partial state; the first post-reset beat SHALL be treated as CP sample 0.

Verification
REQ-033 Defaults, 3 symbols of 80 ramp samples (0..239), o_tready=1: exactly 192 outputs, values 16..79, 96..159, 176..239; tlast on 79, 159, 239; trunc never asserted.
REQ-034 Write cp_len=0 and fft_len_log2=3 mid-stream: the current symbol completes with the old sizes; following output groups are 8 contiguous samples with tlast every 8th.
REQ-035 Random o_tready (50%) and random i_tvalid over 1000 symbols: output sequence identical to the REQ-033 model, no beat loss or duplication, o_tdata stable while o_tvalid & ~o_tready.
REQ-036 i_tlast on sample 40 of an 80-sample symbol with defaults: output 16..40 with tlast on 40, one trunc pulse; the next beat is treated as CP.
REQ-037 clear asserted while o_tvalid=1 and o_tready=0: next cycle o_tvalid=0; the following 16 input beats are dropped.
REQ-038 aresetn pulsed low mid-PASS: outputs go to 0 immediately without a clock edge; the REQ-033 sequence is reproduced afterward.
